// File: rtl/aes_round_word_ctrl.sv
// Word-serial AES-128 round sequencer: walks rounds 0..NUM_ROUNDS one
// key word per accepted cycle and decodes per-round bypass controls.
module aes_round_word_ctrl #(
  parameter int NUM_ROUNDS      = 10,
  parameter int WORDS_PER_BLOCK = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       rnd_key_vld,
  output logic       key_req,
  output logic [5:0] key_addr,
  output logic [3:0] rnd_num,
  output logic [1:0] word_idx,
  output logic       word_vld,
  output logic       sub_bypass,
  output logic       mix_bypass,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ROUND,
    FINAL,
    DONE
  } state_t;

  localparam logic [1:0] LAST_WORD = 2'(WORDS_PER_BLOCK - 1);
  localparam logic [3:0] PEN_RND   = 4'(NUM_ROUNDS - 1);

  state_t     state, state_d;
  logic [3:0] rnd_q, rnd_d;
  logic [1:0] word_q, word_d;
  logic       last_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rnd_q  <= '0;
      word_q <= '0;
    end else begin
      state  <= state_d;
      rnd_q  <= rnd_d;
      word_q <= word_d;
    end
  end

  assign key_req   = (state == INIT) ||
                     (state == ROUND) ||
                     (state == FINAL);
  assign word_vld  = key_req & rnd_key_vld;
  assign last_word = (word_q == LAST_WORD);

  always_comb begin
    state_d = state;
    rnd_d   = rnd_q;
    word_d  = word_q;
    if (abort) begin
      state_d = IDLE;
      rnd_d   = '0;
      word_d  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_d = INIT;
            rnd_d   = '0;
            word_d  = '0;
          end
        end
        INIT, ROUND, FINAL: begin
          if (word_vld) begin
            word_d = word_q + 2'd1;
            if (last_word) begin
              rnd_d = rnd_q + 4'd1;
              unique case (state)
                INIT:  state_d = ROUND;
                ROUND: begin
                  if (rnd_q == PEN_RND)
                    state_d = FINAL;
                end
                default: begin
                  // Block finished: counters park at zero.
                  state_d = DONE;
                  rnd_d   = '0;
                  word_d  = '0;
                end
              endcase
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign rnd_num    = rnd_q;
  assign word_idx   = word_q;
  assign key_addr   = {rnd_q, word_q};
  assign sub_bypass = (state == INIT);
  assign mix_bypass = (state == INIT) ||
                      (state == FINAL);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_aes_round_word_ctrl.sv
// Scoreboard bench for aes_round_word_ctrl: expected key words and
// bypass flags are queued per block and popped on each word_vld.
module tb_aes_round_word_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       rnd_key_vld;
  logic       key_req;
  logic [5:0] key_addr;
  logic [3:0] rnd_num;
  logic [1:0] word_idx;
  logic       word_vld;
  logic       sub_bypass;
  logic       mix_bypass;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] exp_q[$];

  aes_round_word_ctrl #(
    .NUM_ROUNDS(10),
    .WORDS_PER_BLOCK(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .rnd_key_vld(rnd_key_vld),
    .key_req(key_req),
    .key_addr(key_addr),
    .rnd_num(rnd_num),
    .word_idx(word_idx),
    .word_vld(word_vld),
    .sub_bypass(sub_bypass),
    .mix_bypass(mix_bypass),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pack(input int a);
    logic [5:0] aa;
    logic       s;
    logic       m;
    aa = 6'(a);
    s  = (a < 4);
    m  = (a < 4) || (a >= 40);
    return {aa, s, m};
  endfunction

  function automatic logic [8:0] all_outs();
    return {key_req, key_addr, word_vld,
            sub_bypass, mix_bypass};
  endfunction

  // Runs one block; cycle 1 is the first cycle after start is sampled.
  task automatic run_block(
    input int stall_at,
    input int stall_len,
    input int restart_at,
    input int abort_at,
    input int rst_at
  );
    int         n;
    int         stalls;
    int         done_cyc;
    int         pulses;
    int         dones;
    bit         stop;
    bit         cut;
    logic [7:0] e;
    n = 0; stalls = 0; done_cyc = -1;
    pulses = 0; dones = 0; stop = 0; cut = 0;
    exp_q.delete();
    for (int a = 0; a < 44; a++)
      exp_q.push_back(pack(a));
    @(posedge clk); #1;
    start = 1'b1;
    rnd_key_vld = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc < 120 && !stop; cyc++) begin
      start = (cyc == restart_at);
      abort = (n == abort_at);
      rnd_key_vld = !(n == stall_at && stalls < stall_len);
      if (!rnd_key_vld) stalls++;
      @(negedge clk);
      if (word_vld) begin
        pulses++;
        if (exp_q.size() == 0) begin
          check("extra_word", 32'(key_addr), 32'hffff);
        end else begin
          e = exp_q.pop_front();
          check("word", {key_addr, sub_bypass, mix_bypass}, 32'(e));
        end
        n++;
      end else if (!rnd_key_vld && n < 44) begin
        check("stall", {key_req, key_addr}, {1'b1, 6'(n)});
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
      if (abort) begin
        check("abort_vld", 32'(pulses), 32'(abort_at + 1));
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_idle",
              {busy, done, key_req, rnd_num, word_idx, key_addr},
              32'h0);
        stop = 1; cut = 1;
      end else if (rst_at >= 0 && n == rst_at + 1) begin
        #1 rst = 1'b1;
        #1 check("rst_async", {all_outs(), busy, done}, 32'h0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_idle", {busy, rnd_num, word_idx}, 32'h0);
        stop = 1; cut = 1;
      end else if (done_cyc > 0 && cyc == done_cyc + 1) begin
        check("idle_after", {busy, done}, 32'h0);
        stop = 1;
      end
      if (!stop) begin
        @(posedge clk); #1;
      end
    end
    if (!stop) check("timeout", 32'(stop), 32'h1);
    if (cut) begin
      check("no_done", 32'(dones), 32'h0);
    end else begin
      check("done_cyc", 32'(done_cyc), 32'(45 + stall_len));
      check("pulses", 32'(pulses), 32'd44);
      check("dones", 32'(dones), 32'd1);
      check("q_empty", 32'(exp_q.size()), 32'h0);
    end
    start = 1'b0;
    abort = 1'b0;
    rnd_key_vld = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    rnd_key_vld = 1'b0;
    #12;
    check("rst_outs", {all_outs(), busy, done}, 32'h0);
    check("rst_cnt", {rnd_num, word_idx}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    run_block(-1, 0, -1, -1, -1);
    run_block(17, 3, -1, -1, -1);
    run_block(-1, 0, 10, -1, -1);
    run_block(-1, 0, -1, 22, -1);
    run_block(-1, 0, -1, -1, -1);
    run_block(-1, 0, -1, -1, 30);

    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    rnd_key_vld = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("start_abort", {busy, key_req, word_vld}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("start_abort2", {busy, key_req}, 32'h0);
    rnd_key_vld = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
